// File: rtl/axo_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Also holds the saturating hold-counter helper used by the top level.
package axo_arb_pkg;

    localparam int CNT_W  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Increments the hold counter and clamps it at the limit. The counter
    // never runs past hold_max, so it cannot wrap during long single-owner bursts.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W:0]   lim);
        logic [CNT_W:0] nxt;
        nxt = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        sat_inc = (nxt > lim) ? lim[CNT_W-1:0] : nxt[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/axo_mem_bus.sv
// Simple single-cycle memory bus; CPU side issues requests, MEM side answers.
interface axo_mem_bus;
    import axo_arb_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        asize;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              error;

    modport CPU (
        output addr, asize, re, we, wdata,
        input  ready, error, rdata
    );

    modport MEM (
        input  addr, asize, re, we, wdata,
        output ready, error, rdata
    );

endinterface

// File: rtl/axo_rr_pick2.sv
// Two-way priority pick: a lone requester wins; on a tie, port ptr wins.
module axo_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // NOTE: grant gets a default before the conditional override so no latch is inferred.
    always_comb begin
        grant = req;
        if (&req) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axo_mem_arbiter.sv
// Zero-latency two-port arbiter in front of a single RAM port, with a bounded
// hold count so one busy requester cannot starve the other.
module axo_mem_arbiter
    import axo_arb_pkg::*;
#(
    parameter int hold_max = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    axo_mem_bus.MEM    req0,
    axo_mem_bus.MEM    req1,
    axo_mem_bus.CPU    mem,
    output logic [1:0] owner
);

    localparam logic [CNT_W:0] HOLD_LIM = (CNT_W + 1)'(hold_max);

    arb_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            ptr;

    logic [1:0]      req;
    logic [1:0]      grant;
    logic            own_valid;
    logic            own_idx;
    logic            owner_req;
    logic            other_req;
    logic            done;
    logic            hand_over;
    logic [CNT_W:0]  cnt_inc;

    assign req = {req1.re | req1.we, req0.re | req0.we};

    axo_rr_pick2 u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    // In IDLE the owner is whatever the pick chooses this very cycle.
    always_comb begin
        own_valid = 1'b0;
        own_idx   = 1'b0;
        case (state)
            ST_OWN0: begin
                own_valid = 1'b1;
                own_idx   = 1'b0;
            end
            ST_OWN1: begin
                own_valid = 1'b1;
                own_idx   = 1'b1;
            end
            default: begin
                own_valid = |grant;
                own_idx   = grant[1];
            end
        endcase
    end

    assign owner_req = own_valid & req[own_idx];
    assign other_req = own_valid & req[~own_idx];
    // An error response ends the access just like ready does.
    assign done      = owner_req & (mem.ready | mem.error);
    assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign hand_over = other_req & (cnt_inc >= HOLD_LIM);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
        end else if (state != ST_IDLE && !owner_req) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= ~own_idx;
        end else if (done) begin
            if (hand_over) begin
                state <= own_idx ? ST_OWN0 : ST_OWN1;
                cnt   <= '0;
            end else begin
                state <= own_idx ? ST_OWN1 : ST_OWN0;
                cnt   <= sat_inc(cnt, HOLD_LIM);
            end
        end
    end

    assign mem.addr  = !own_valid ? '0   : (own_idx ? req1.addr  : req0.addr);
    assign mem.asize = !own_valid ? '0   : (own_idx ? req1.asize : req0.asize);
    assign mem.re    = !own_valid ? 1'b0 : (own_idx ? req1.re    : req0.re);
    assign mem.we    = !own_valid ? 1'b0 : (own_idx ? req1.we    : req0.we);
    assign mem.wdata = !own_valid ? '0   : (own_idx ? req1.wdata : req0.wdata);

    assign req0.ready = own_valid & ~own_idx & mem.ready;
    assign req0.error = own_valid & ~own_idx & mem.error;
    assign req0.rdata = (own_valid & ~own_idx) ? mem.rdata : '0;

    assign req1.ready = own_valid & own_idx & mem.ready;
    assign req1.error = own_valid & own_idx & mem.error;
    assign req1.rdata = (own_valid & own_idx) ? mem.rdata : '0;

    assign owner = !own_valid ? 2'b00 : (own_idx ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_axo_mem_arbiter.sv
// Directed bench for axo_mem_arbiter: one instance at hold_max=4, one at hold_max=1.
module tb_axo_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] owner_a;
    logic [1:0] owner_b;

    int n_checks = 0;
    int n_fail   = 0;

    axo_mem_bus a_p0 ();
    axo_mem_bus a_p1 ();
    axo_mem_bus a_m  ();
    axo_mem_bus b_p0 ();
    axo_mem_bus b_p1 ();
    axo_mem_bus b_m  ();

    axo_mem_arbiter #(.hold_max(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (a_p0),
        .req1  (a_p1),
        .mem   (a_m),
        .owner (owner_a)
    );

    axo_mem_arbiter #(.hold_max(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (b_p0),
        .req1  (b_p1),
        .mem   (b_m),
        .owner (owner_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_all();
        a_p0.addr = '0; a_p0.asize = '0; a_p0.re = 1'b0; a_p0.we = 1'b0; a_p0.wdata = '0;
        a_p1.addr = '0; a_p1.asize = '0; a_p1.re = 1'b0; a_p1.we = 1'b0; a_p1.wdata = '0;
        b_p0.addr = '0; b_p0.asize = '0; b_p0.re = 1'b0; b_p0.we = 1'b0; b_p0.wdata = '0;
        b_p1.addr = '0; b_p1.asize = '0; b_p1.re = 1'b0; b_p1.we = 1'b0; b_p1.wdata = '0;
        a_m.ready = 1'b0; a_m.error = 1'b0; a_m.rdata = '0;
        b_m.ready = 1'b0; b_m.error = 1'b0; b_m.rdata = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released and all inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [1:0] seq_a [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        rst_n = 1'b0;
        idle_all();
        #12;
        check("rst_owner_a", {30'd0, owner_a}, 32'h0);
        check("rst_owner_b", {30'd0, owner_b}, 32'h0);
        check("rst_mem_re", {31'd0, a_m.re}, 32'h0);
        check("rst_mem_addr", a_m.addr, 32'h0);

        // Single requester: port 0 reads 0x10, zero-latency pass-through.
        do_reset();
        a_p0.re = 1'b1; a_p0.addr = 32'h10; a_p0.asize = 2'd2;
        a_m.ready = 1'b1; a_m.rdata = 32'hCAFE_0001;
        @(negedge clk);
        check("single_mem_addr", a_m.addr, 32'h10);
        check("single_mem_asize", {30'd0, a_m.asize}, 32'd2);
        check("single_mem_re", {31'd0, a_m.re}, 32'h1);
        check("single_owner", {30'd0, owner_a}, 32'h1);
        check("single_p0_rdata", a_p0.rdata, 32'hCAFE_0001);
        check("single_p0_ready", {31'd0, a_p0.ready}, 32'h1);
        check("single_p1_ready", {31'd0, a_p1.ready}, 32'h0);

        // Both request from IDLE: port 0 first, handover after four transfers.
        do_reset();
        a_p0.we = 1'b1; a_p0.addr = 32'h100; a_p0.wdata = 32'h1111_2222;
        a_p1.re = 1'b1; a_p1.addr = 32'h200;
        a_m.ready = 1'b1; a_m.rdata = 32'h5A5A_0000;
        for (int i = 0; i < 9; i++) begin
            a_m.error = (i == 5);
            @(negedge clk);
            check($sformatf("both_owner_%0d", i), {30'd0, owner_a}, {30'd0, seq_a[i]});
            if (i == 0) begin
                check("both_mem_we", {31'd0, a_m.we}, 32'h1);
                check("both_mem_wdata", a_m.wdata, 32'h1111_2222);
                check("both_p1_rdata_blocked", a_p1.rdata, 32'h0);
            end
            if (i == 4) begin
                check("both_mem_addr_p1", a_m.addr, 32'h200);
                check("both_mem_we_p1", {31'd0, a_m.we}, 32'h0);
                check("both_p1_rdata", a_p1.rdata, 32'h5A5A_0000);
                check("both_p0_ready_blocked", {31'd0, a_p0.ready}, 32'h0);
            end
            if (i == 5) begin
                check("err_to_owner", {31'd0, a_p1.error}, 32'h1);
                check("err_not_other", {31'd0, a_p0.error}, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        a_m.error = 1'b0;

        // Stall for three cycles, then four completions before handover.
        do_reset();
        a_p0.re = 1'b1; a_p0.addr = 32'h40;
        a_p1.re = 1'b1; a_p1.addr = 32'h80;
        for (int i = 0; i < 8; i++) begin
            a_m.ready = (i >= 3);
            @(negedge clk);
            check($sformatf("stall_owner_%0d", i), {30'd0, owner_a},
                  (i == 7) ? 32'h2 : 32'h1);
            @(posedge clk);
            #1;
        end

        // Release sets ptr to the other port; a tie next cycle goes to ptr.
        do_reset();
        a_p1.re = 1'b1; a_m.ready = 1'b1;
        @(negedge clk);
        check("rel_p1_alone", {30'd0, owner_a}, 32'h2);
        @(posedge clk); #1;
        a_p1.re = 1'b0;
        @(negedge clk);
        check("rel_own1_noreq", {30'd0, owner_a}, 32'h2);
        check("rel_own1_mem_re", {31'd0, a_m.re}, 32'h0);
        @(posedge clk); #1;
        a_p0.re = 1'b1; a_p1.re = 1'b1;
        @(negedge clk);
        check("rel_tie_ptr0", {30'd0, owner_a}, 32'h1);
        @(posedge clk); #1;
        a_p0.re = 1'b0; a_p1.re = 1'b0;
        @(negedge clk);
        check("rel_own0_noreq", {30'd0, owner_a}, 32'h1);
        @(posedge clk); #1;
        a_p0.re = 1'b1; a_p1.re = 1'b1;
        @(negedge clk);
        check("rel_tie_ptr1", {30'd0, owner_a}, 32'h2);
        @(posedge clk); #1;
        a_p0.re = 1'b0; a_p1.re = 1'b0;
        @(posedge clk); #1;
        check("rel_idle_none", {30'd0, owner_a}, 32'h0);

        // Reset pulled 2 ns into an OWN1 cycle takes effect without a clock edge.
        do_reset();
        a_p1.re = 1'b1; a_m.ready = 1'b1;
        @(negedge clk);
        check("rstmid_pre_owner", {30'd0, owner_a}, 32'h2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        a_p1.re = 1'b0;
        #1;
        check("rstmid_owner", {30'd0, owner_a}, 32'h0);
        check("rstmid_mem_re", {31'd0, a_m.re}, 32'h0);
        check("rstmid_mem_we", {31'd0, a_m.we}, 32'h0);

        // hold_max=1: strict alternation on every completion.
        do_reset();
        b_p0.re = 1'b1; b_p1.we = 1'b1; b_m.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("alt_owner_%0d", i), {30'd0, owner_b},
                  i[0] ? 32'h2 : 32'h1);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
